// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the text-VRAM port-A arbiter and its clear engine.
package vram_arb_pkg;

    localparam int VRAM_NUM_WORDS = 600;
    localparam int VRAM_ADDR_W    = 12;
    localparam int VRAM_DATA_W    = 32;
    localparam int PALETTE_BIT    = 11;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_t;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [3:0]             byteena;
        logic [VRAM_DATA_W-1:0] data;
        logic                   wren;
        logic                   rden;
    } ram_req_t;

endpackage

// File: rtl/vram_clear_engine.sv
// Fills every VRAM word with a latched pattern, one word per cycle for NUM_WORDS cycles.
// Never stalls once started; clr_start outside CLR_IDLE is ignored; done pulses one cycle after the last write.
module vram_clear_engine
    import vram_arb_pkg::*;
#(
    parameter int NUM_WORDS = VRAM_NUM_WORDS
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   clr_start,
    input  logic [VRAM_DATA_W-1:0] clr_data,
    output ram_req_t               clr_req,
    output logic                   clr_busy,
    output logic                   clr_done
);

    localparam logic [VRAM_ADDR_W-1:0] LAST_WORD = VRAM_ADDR_W'(NUM_WORDS - 1);

    clr_state_t             state;
    logic [VRAM_ADDR_W-1:0] cnt;
    logic [VRAM_DATA_W-1:0] fill;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= CLR_IDLE;
            cnt      <= '0;
            fill     <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        fill     <= clr_data;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                        state    <= CLR_RUN;
                    end
                end
                CLR_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_WORD) begin
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= CLR_DONE;
                    end
                end
                CLR_DONE: state <= CLR_IDLE;
                default:  state <= CLR_IDLE;
            endcase
        end
    end

    assign clr_req = '{addr: cnt, byteena: 4'hF, data: fill, wren: (state == CLR_RUN), rden: 1'b0};

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares VRAM port A between clear engine > {Avalon CPU, cell writer}; single-cycle combinational grant, reads return 1 cycle later.
// Losers stall via AVL_WAITREQUEST / withheld cw_ack; VRAM_ARB_RR_EN selects round-robin CPU/cell arbitration (default: CPU first).
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int NUM_WORDS = VRAM_NUM_WORDS,
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [DATA_W-1:0] AVL_WRITEDATA,
    output logic [DATA_W-1:0] AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    output logic              AVL_READDATAVALID,
    input  logic              cw_req,
    input  logic [ADDR_W-1:0] cw_addr,
    input  logic [3:0]        cw_byte_en,
    input  logic [DATA_W-1:0] cw_data,
    output logic              cw_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_data,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [3:0]        ram_byteena_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_wren_a,
    output logic              ram_rden_a,
    input  logic [DATA_W-1:0] ram_q_a
);

    ram_req_t clr_req;
    ram_req_t sel;
    logic     avl_req, pal_hit, cpu_ram_req;
    logic     cpu_in_range, cw_in_range;
    logic     cpu_ram_grant, cpu_grant, cw_grant, cpu_rd;
    logic     rd_vld_q, rd_ram_q;

    vram_clear_engine #(.NUM_WORDS(NUM_WORDS)) u_clear (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr_start (clr_start),
        .clr_data  (clr_data),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    assign avl_req      = AVL_CS & (AVL_READ | AVL_WRITE);
    assign pal_hit      = AVL_ADDR[PALETTE_BIT];
    assign cpu_ram_req  = avl_req & ~pal_hit;
    // Palette addresses sit above NUM_WORDS, so they also read as out of range.
    assign cpu_in_range = (AVL_ADDR < ADDR_W'(NUM_WORDS));
    assign cw_in_range  = (cw_addr < ADDR_W'(NUM_WORDS));

`ifdef VRAM_ARB_RR_EN
    logic conflict;
    logic rr_cw_next;

    assign conflict = ~clr_busy & cpu_ram_req & cw_req;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            rr_cw_next <= 1'b0;
        else if (conflict)
            rr_cw_next <= ~rr_cw_next;
    end

    always_comb begin
        cpu_ram_grant = 1'b0;
        cw_grant      = 1'b0;
        if (!clr_busy) begin
            if (conflict) begin
                cw_grant      = rr_cw_next;
                cpu_ram_grant = ~rr_cw_next;
            end else begin
                cpu_ram_grant = cpu_ram_req;
                cw_grant      = cw_req;
            end
        end
    end
`else
    always_comb begin
        cpu_ram_grant = 1'b0;
        cw_grant      = 1'b0;
        if (!clr_busy) begin
            cpu_ram_grant = cpu_ram_req;
            cw_grant      = cw_req & ~cpu_ram_req;
        end
    end
`endif

    assign cpu_grant       = (avl_req & pal_hit) | cpu_ram_grant;
    assign AVL_WAITREQUEST = avl_req & ~cpu_grant;
    assign cw_ack          = cw_grant;

    always_comb begin
        sel = '0;
        if (clr_busy) begin
            sel = clr_req;
        end else if (cpu_ram_grant) begin
            sel.addr    = AVL_ADDR;
            sel.byteena = AVL_BYTE_EN;
            sel.data    = AVL_WRITEDATA;
            sel.wren    = AVL_WRITE & cpu_in_range;
            sel.rden    = AVL_READ & ~AVL_WRITE & cpu_in_range;
        end else if (cw_grant) begin
            sel.addr    = cw_addr;
            sel.byteena = cw_byte_en;
            sel.data    = cw_data;
            sel.wren    = cw_in_range;
        end
    end

    assign ram_addr_a    = sel.addr;
    assign ram_byteena_a = sel.byteena;
    assign ram_data_a    = sel.data;
    assign ram_wren_a    = sel.wren;
    assign ram_rden_a    = sel.rden;

    // Palette and out-of-range reads still answer, but with zero instead of RAM data.
    assign cpu_rd = cpu_grant & AVL_READ & ~AVL_WRITE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_vld_q <= 1'b0;
            rd_ram_q <= 1'b0;
        end else begin
            rd_vld_q <= cpu_rd;
            rd_ram_q <= cpu_rd & ~pal_hit & cpu_in_range;
        end
    end

    assign AVL_READDATAVALID = rd_vld_q;
    assign AVL_READDATA      = rd_ram_q ? ram_q_a : '0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural VRAM and a cycle-level reference model.
`timescale 1ns/1ps
module tb_vram_port_arbiter;

    localparam int NW = 600;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
    logic [3:0]  AVL_BYTE_EN = 4'h0;
    logic [11:0] AVL_ADDR = '0;
    logic [31:0] AVL_WRITEDATA = '0;
    logic [31:0] AVL_READDATA;
    logic        AVL_WAITREQUEST, AVL_READDATAVALID;
    logic        cw_req = 1'b0;
    logic [11:0] cw_addr = '0;
    logic [3:0]  cw_byte_en = 4'h0;
    logic [31:0] cw_data = '0;
    logic        cw_ack;
    logic        clr_start = 1'b0;
    logic [31:0] clr_data = '0;
    logic        clr_busy, clr_done;
    logic [11:0] ram_addr_a;
    logic [3:0]  ram_byteena_a;
    logic [31:0] ram_data_a;
    logic        ram_wren_a, ram_rden_a;
    logic [31:0] ram_q_a = '0;

    always #5 CLK = ~CLK;

    vram_port_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
        .AVL_READDATAVALID(AVL_READDATAVALID),
        .cw_req(cw_req), .cw_addr(cw_addr), .cw_byte_en(cw_byte_en), .cw_data(cw_data),
        .cw_ack(cw_ack),
        .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr_a(ram_addr_a), .ram_byteena_a(ram_byteena_a), .ram_data_a(ram_data_a),
        .ram_wren_a(ram_wren_a), .ram_rden_a(ram_rden_a), .ram_q_a(ram_q_a)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural VRAM on port A.
    logic [31:0] vram [0:1023];
    always @(posedge CLK) begin
        if (ram_wren_a)
            for (int b = 0; b < 4; b++)
                if (ram_byteena_a[b]) vram[ram_addr_a[9:0]][8*b +: 8] <= ram_data_a[8*b +: 8];
        if (ram_rden_a) ram_q_a <= vram[ram_addr_a[9:0]];
    end

    // Reference model: evaluated mid-cycle, then advanced to the state after the next edge.
    logic [31:0] ref_mem [0:NW-1];
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_fill = '0;
    bit          m_pref_cw = 1'b0;
    bit          m_rd_pend = 1'b0;
    logic [31:0] m_rd_data = '0;

    always @(negedge CLK) begin
        bit avl, pal, cpu_ram, cpu_win, cw_win, running, idle;
        if (!RESET) begin
            m_left = 0; m_done = 1'b0; m_pref_cw = 1'b0; m_rd_pend = 1'b0; m_rd_data = '0;
        end else begin
            avl     = AVL_CS && (AVL_READ || AVL_WRITE);
            pal     = AVL_ADDR[11];
            cpu_ram = avl && !pal;
            running = (m_left > 0);
            cpu_win = 1'b0;
            cw_win  = 1'b0;
            if (!running) begin
                if (cpu_ram && cw_req) begin
`ifdef VRAM_ARB_RR_EN
                    cw_win    = m_pref_cw;
                    cpu_win   = !m_pref_cw;
                    m_pref_cw = !m_pref_cw;
`else
                    cpu_win = 1'b1;
`endif
                end else begin
                    cpu_win = cpu_ram;
                    cw_win  = cw_req;
                end
            end
            chk("m_waitrequest", AVL_WAITREQUEST, avl && !pal && !cpu_win);
            chk("m_cw_ack", cw_ack, cw_win);
            chk("m_clr_busy", clr_busy, running);
            chk("m_clr_done", clr_done, m_done);
            chk("m_rd_valid", AVL_READDATAVALID, m_rd_pend);
            chk("m_rd_data", AVL_READDATA, m_rd_pend ? m_rd_data : 32'h0);
            if (ram_wren_a) chk("m_wren_in_range", ram_addr_a < NW, 1);

            idle      = !running && !m_done;
            m_rd_pend = avl && AVL_READ && !AVL_WRITE && (pal || cpu_win);
            m_rd_data = '0;
            if (m_rd_pend && !pal && AVL_ADDR < NW) m_rd_data = ref_mem[AVL_ADDR];
            m_done = (m_left == 1);
            if (running) begin
                ref_mem[NW - m_left] = m_fill;
                m_left--;
            end else if (idle && clr_start) begin
                m_left = NW;
                m_fill = clr_data;
            end
            if (cpu_win && AVL_WRITE && AVL_ADDR < NW)
                for (int b = 0; b < 4; b++)
                    if (AVL_BYTE_EN[b]) ref_mem[AVL_ADDR][8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
            if (cw_win && cw_addr < NW)
                for (int b = 0; b < 4; b++)
                    if (cw_byte_en[b]) ref_mem[cw_addr][8*b +: 8] = cw_data[8*b +: 8];
        end
    end

    // All tasks start and end 1 ns after a rising edge.
    task automatic avl_write(input logic [11:0] a, input logic [31:0] d, output int wc);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = 4'hF;
        wc = 0;
        @(negedge CLK);
        while (AVL_WAITREQUEST && wc < 2000) begin wc++; @(negedge CLK); end
        chk("wr_no_timeout", wc < 2000, 1);
        @(posedge CLK); #1;
        AVL_CS = 0; AVL_WRITE = 0;
    endtask

    task automatic avl_read(input logic [11:0] a, output logic [31:0] d, output int wc);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a; AVL_BYTE_EN = 4'hF;
        wc = 0;
        @(negedge CLK);
        while (AVL_WAITREQUEST && wc < 2000) begin wc++; @(negedge CLK); end
        chk("rd_no_timeout", wc < 2000, 1);
        chk("rd_valid_not_early", AVL_READDATAVALID, 0);
        @(posedge CLK); #1;
        AVL_CS = 0; AVL_READ = 0;
        @(negedge CLK);
        chk("rd_valid_next_cycle", AVL_READDATAVALID, 1);
        d = AVL_READDATA;
        @(posedge CLK); #1;
    endtask

    task automatic start_clear(input logic [31:0] fill);
        clr_data = fill; clr_start = 1;
        @(posedge CLK); #1;
        clr_start = 0;
    endtask

    logic [31:0] d;
    int          wc, busy_cnt, done_cnt, ack_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = '0;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_rd_valid", AVL_READDATAVALID, 0);
        chk("rst_readdata", AVL_READDATA, 0);
        chk("rst_wren", ram_wren_a, 0);
        chk("rst_rden", ram_rden_a, 0);
        chk("rst_cw_ack", cw_ack, 0);
        chk("rst_waitreq", AVL_WAITREQUEST, 0);
        RESET = 1;
        @(posedge CLK); #1;

        // 1: basic write/read and palette read
        avl_write(12'd5, 32'h0000_4141, wc);
        chk("t1_wr_wait", wc, 0);
        avl_read(12'd5, d, wc);
        chk("t1_rd_wait", wc, 0);
        chk("t1_rd_data", d, 32'h0000_4141);
        avl_read(12'h800, d, wc);
        chk("t1_pal_rd_wait", wc, 0);
        chk("t1_pal_rd_data", d, 32'h0);

        // 2: full clear
        start_clear(32'h2020_2020);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge CLK);
            busy_cnt += int'(clr_busy);
            done_cnt += int'(clr_done);
        end
        @(posedge CLK); #1;
        chk("t2_busy_cycles", busy_cnt, 600);
        chk("t2_done_pulses", done_cnt, 1);
        avl_read(12'd0, d, wc);   chk("t2_rd0", d, 32'h2020_2020);
        avl_read(12'd599, d, wc); chk("t2_rd599", d, 32'h2020_2020);
        avl_read(12'd5, d, wc);   chk("t2_rd5", d, 32'h2020_2020);
        avl_read(12'd600, d, wc); chk("t2_rd600", d, 32'h0);

        // 3: CPU traffic during a clear
        start_clear(32'h1111_1111);
        repeat (5) @(posedge CLK);
        #1;
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 12'h800; AVL_WRITEDATA = 32'h00AB_CDEF;
        @(negedge CLK);
        chk("t3_pal_wr_wait", AVL_WAITREQUEST, 0);
        chk("t3_pal_wr_busy", clr_busy, 1);
        @(posedge CLK); #1;
        AVL_CS = 0; AVL_WRITE = 0;
        avl_read(12'd10, d, wc);
        chk("t3_rd_stall_cycles", wc, 594);
        chk("t3_rd_data", d, 32'h1111_1111);

        // 4: CPU and cell writer contend for 8 cycles
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 12'd20; AVL_WRITEDATA = 32'hA5A5_0020; AVL_BYTE_EN = 4'hF;
        cw_req = 1; cw_addr = 12'd30; cw_data = 32'h5A5A_0030; cw_byte_en = 4'hF;
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
`ifdef VRAM_ARB_RR_EN
            chk("t4_cw_ack_alt", cw_ack, (i % 2) == 1);
`else
            chk("t4_cw_ack_fixed", cw_ack, 0);
`endif
            chk("t4_one_winner", AVL_WAITREQUEST, cw_ack);
            ack_cnt += int'(cw_ack);
            @(posedge CLK); #1;
        end
        AVL_CS = 0; AVL_WRITE = 0; cw_req = 0;
`ifdef VRAM_ARB_RR_EN
        chk("t4_ack_total", ack_cnt, 4);
`else
        chk("t4_ack_total", ack_cnt, 0);
`endif

        // 5: out-of-range cell write
        cw_req = 1; cw_addr = 12'd700; cw_data = 32'hDEAD_BEEF; cw_byte_en = 4'hF;
        @(negedge CLK);
        chk("t5_cw_ack", cw_ack, 1);
        chk("t5_wren", ram_wren_a, 0);
        @(posedge CLK); #1;
        cw_req = 0;
        avl_read(12'd20, d, wc); chk("t5_rd20", d, 32'hA5A5_0020);
`ifdef VRAM_ARB_RR_EN
        avl_read(12'd30, d, wc); chk("t5_rd30", d, 32'h5A5A_0030);
`else
        avl_read(12'd30, d, wc); chk("t5_rd30", d, 32'h1111_1111);
`endif

        // 6: reset after 300 clear writes
        start_clear(32'h3333_3333);
        repeat (300) @(posedge CLK);
        #1;
        RESET = 0;
        #1;
        chk("t6_busy_on_reset", clr_busy, 0);
        done_cnt = 0;
        repeat (3) @(negedge CLK) done_cnt += int'(clr_done);
        @(posedge CLK); #1;
        RESET = 1;
        repeat (4) @(negedge CLK) done_cnt += int'(clr_done) + int'(clr_busy);
        @(posedge CLK); #1;
        chk("t6_no_done_no_resume", done_cnt, 0);
        avl_read(12'd0, d, wc);   chk("t6_rd0", d, 32'h3333_3333);
        avl_read(12'd299, d, wc); chk("t6_rd299", d, 32'h3333_3333);
        avl_read(12'd300, d, wc); chk("t6_rd300", d, 32'h1111_1111);
        avl_read(12'd599, d, wc); chk("t6_rd599", d, 32'h1111_1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
